// File: rtl/led_pkg.sv
// Shared types and mode encodings for the LED controller.
package led_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t LED_OFF   = 2'd0;
  localparam led_mode_t LED_ON    = 2'd1;
  localparam led_mode_t LED_BLINK = 2'd2;
  localparam led_mode_t LED_PWM   = 2'd3;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its configuration, a tick counter and the
// registered LED level. A write always takes priority over a tick.
module led_channel
  import led_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             wr,
  input  led_mode_t        mode,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             led
);

  led_mode_t        mode_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] duty_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             led_reg;

  // The counter wraps when it reaches the period, so cnt+1 never passes it.
  logic wrap;
  assign wrap = (cnt_reg >= period_reg);

  // Configuration load on write, otherwise advance the active mode on tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg   <= LED_OFF;
      period_reg <= '0;
      duty_reg   <= '0;
      cnt_reg    <= '0;
      led_reg    <= 1'b0;
    end else if (wr) begin
      mode_reg   <= mode;
      period_reg <= period;
      duty_reg   <= duty;
      cnt_reg    <= '0;
      led_reg    <= (mode == LED_ON);
    end else if (tick) begin
      case (mode_reg)
        LED_OFF: begin
          led_reg <= 1'b0;
          cnt_reg <= '0;
        end
        LED_ON: begin
          led_reg <= 1'b1;
          cnt_reg <= '0;
        end
        LED_BLINK: begin
          if (wrap) begin
            cnt_reg <= '0;
            led_reg <= ~led_reg;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          // PWM: high for the first `duty` ticks of each period+1 frame.
          led_reg <= (cnt_reg < duty_reg);
          cnt_reg <= wrap ? '0 : cnt_reg + CNT_W'(1);
        end
      endcase
    end
  end

  assign led = led_reg;

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED controller: shared prescaler, config write decode,
// bad-channel error pulse and one led_channel per output.
module led_ctrl
  import led_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 32,
  parameter  int PRESCALE = 1,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  led_mode_t           cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_duty,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] led
);

  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(CHANNELS);

  logic [PRE_W-1:0]    pre_reg;
  logic [PRE_W-1:0]    pre_next;
  logic                tick;
  logic                ch_valid;
  logic                cfg_err_reg;
  logic [CHANNELS-1:0] wr;

  assign tick     = enable && (pre_reg == PRE_MAX);
  assign ch_valid = ({1'b0, cfg_ch} < CH_LIMIT);

  // Prescaler next value: counts enabled cycles and wraps after PRESCALE-1.
  always_comb begin
    pre_next = pre_reg;
    if (enable) begin
      pre_next = (pre_reg == PRE_MAX) ? '0 : pre_reg + PRE_W'(1);
    end
  end

  // Prescaler state; frozen while enable is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_next;
    end
  end

  // One-cycle error pulse following a write to a nonexistent channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_we && !ch_valid;
    end
  end

  assign cfg_err = cfg_err_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign wr[gi] = cfg_we && ch_valid && (cfg_ch == CH_W'(gi));

    led_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .wr     (wr[gi]),
      .mode   (cfg_mode),
      .period (cfg_period),
      .duty   (cfg_duty),
      .led    (led[gi])
    );
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: two instances (PRESCALE 1 and 4, three channels so an
// out-of-range channel index exists) share one stimulus stream and are
// compared every cycle against a model that derives each LED from the
// number of ticks elapsed since that channel was last written.
module tb_led_ctrl;

  localparam int NCH = 3;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_duty = '0;
  logic          err_a, err_b;
  logic [NCH-1:0] led_a, led_b;

  int n_vec = 0;
  int n_err = 0;

  // Model state, first index selects the instance (0: PRESCALE 1, 1: PRESCALE 4).
  int m_mode[2][NCH];
  int m_per[2][NCH];
  int m_duty[2][NCH];
  int m_n[2][NCH];
  int m_enc[2];
  logic m_err[2];

  led_ctrl #(.CHANNELS(NCH), .CNT_W(CW), .PRESCALE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .cfg_err(err_a), .led(led_a)
  );

  led_ctrl #(.CHANNELS(NCH), .CNT_W(CW), .PRESCALE(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .cfg_err(err_b), .led(led_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ps(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // LED level after n ticks since the last write, straight from the mode rules.
  function automatic logic model_led(input int mode, input int per, input int duty, input int n);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ((n / (per + 1)) % 2) == 1;
      default: return (n == 0) ? 1'b0 : (((n - 1) % (per + 1)) < duty);
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_enc[d] = 0;
      m_err[d] = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[d][c] = 0;
        m_per[d][c]  = 0;
        m_duty[d][c] = 0;
        m_n[d][c]    = 0;
      end
    end
  endtask

  // Apply the effect of one rising edge with the inputs currently driven.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic tk;
      tk = enable && ((m_enc[d] % ps(d)) == ps(d) - 1);
      if (enable) m_enc[d]++;
      m_err[d] = cfg_we && (int'(cfg_ch) >= NCH);
      for (int c = 0; c < NCH; c++) begin
        if (cfg_we && int'(cfg_ch) == c) begin
          m_mode[d][c] = int'(cfg_mode);
          m_per[d][c]  = int'(cfg_period);
          m_duty[d][c] = int'(cfg_duty);
          m_n[d][c]    = 0;
        end else if (tk) begin
          m_n[d][c]++;
        end
      end
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] exp_a, exp_b;
    for (int c = 0; c < NCH; c++) begin
      exp_a[c] = model_led(m_mode[0][c], m_per[0][c], m_duty[0][c], m_n[0][c]);
      exp_b[c] = model_led(m_mode[1][c], m_per[1][c], m_duty[1][c], m_n[1][c]);
    end
    check("led_ps1", 32'(led_a), 32'(exp_a));
    check("led_ps4", 32'(led_b), 32'(exp_b));
    check("err_ps1", 32'(err_a), 32'(m_err[0]));
    check("err_ps4", 32'(err_b), 32'(m_err[1]));
  endtask

  // One clock cycle: drive inputs, take the edge, update the model, compare.
  task automatic step(input logic en, input logic we, input int ch, input int mode,
                      input int per, input int duty);
    enable     = en;
    cfg_we     = we;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = CW'(per);
    cfg_duty   = CW'(duty);
    if (we)
      $display("write ch=%0d mode=%0d period=%0d duty=%0d enable=%0b t=%0t",
               ch, mode, per, duty, en, $time);
    @(posedge clk);
    model_edge();
    #1;
    compare();
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int cycles, input logic en);
    for (int i = 0; i < cycles; i++) step(en, 1'b0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges and check outputs clear without a clock.
  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    $display("reset asserted t=%0t", $time);
    #1;
    model_reset();
    compare();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    compare();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    // Blink ch0 with period 10, then an enable gap mid-period.
    step(1'b1, 1'b1, 0, 2, 10, 0);
    idle(30, 1'b1);
    idle(5, 1'b0);
    idle(40, 1'b1);

    // PWM ch1 period 9 duty 3, then duty 0 and duty 12.
    step(1'b1, 1'b1, 1, 3, 9, 3);
    idle(30, 1'b1);
    step(1'b1, 1'b1, 1, 3, 9, 0);
    idle(20, 1'b1);
    step(1'b1, 1'b1, 1, 3, 9, 12);
    idle(20, 1'b1);

    // Out-of-range channel, then ch2 ON coinciding with a tick.
    step(1'b1, 1'b1, 3, 1, 5, 5);
    step(1'b1, 1'b1, 2, 1, 0, 0);
    idle(10, 1'b1);

    // Blink period 2 on ch2 for the prescaled instance to show a 12-cycle toggle.
    step(1'b1, 1'b1, 2, 2, 2, 0);
    idle(40, 1'b1);

    // Write while disabled: applies, counters stay frozen.
    step(1'b0, 1'b1, 0, 3, 4, 2);
    idle(4, 1'b0);
    idle(15, 1'b1);

    // Reset while channels are active; everything returns to OFF.
    pulse_reset();
    idle(20, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic en, we;
      en = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 19) == 0);
      step(en, we, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
      if (i == 750) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
# led_ctrl

Parametrised multi-channel LED controller. It drives CHANNELS independent LED outputs, each configurable at run time as off, on, blinking with a programmable half-period, or PWM-dimmed with a programmable frame length and duty. A shared prescaler derives a common tick from `clk`, and a single-cycle write port configures one channel at a time. The block sits at the board-I/O edge of the design, driven by a status or control FSM.

## Interface
- `CHANNELS`, default 4: number of LED channels (≥1).
- `CNT_W`, default 32: width of the period, duty and counter fields.
- `PRESCALE`, default 1: clk cycles per tick (≥1); 1 means a tick every cycle.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global run; 0 freezes the prescaler, all counters and all LEDs.
- `cfg_we`  in  1  write strobe, one cycle per write.
- `cfg_ch`  in  max(1,$clog2(CHANNELS))  target channel.
- `cfg_mode`  in  2  0 OFF, 1 ON, 2 BLINK, 3 PWM.
- `cfg_period`  in  CNT_W  blink half-period, or PWM frame length minus 1.
- `cfg_duty`  in  CNT_W  PWM high ticks per frame; ignored in other modes.
- `cfg_err`  out  1  registered one-cycle pulse on a write to `cfg_ch` ≥ CHANNELS.
- `led`  out  CHANNELS  registered LED outputs, bit i = channel i.

## Operation
Reset (`reset_n`=0, asynchronous): every channel is set to mode OFF with period 0, duty 0, cnt 0 and `led`=0. The prescaler is set to 0 and `cfg_err` to 0.

Prescaler: `pre` counts 0..PRESCALE-1 while `enable`=1. `tick` = `enable` && `pre`==PRESCALE-1. When `pre` reaches PRESCALE-1 it wraps to 0.

Config write, valid channel (`cfg_we`=1, `cfg_ch`<CHANNELS), at that edge:
- mode, period and duty are loaded;
- cnt <= 0;
- `led[ch]` <= (cfg_mode==ON).
- The write takes effect even when `enable`=0.

Config write, invalid channel: no state changes; `cfg_err`=1 in the following cycle.

Per channel, on tick:
- OFF: `led`=0, cnt=0.
- ON: `led`=1, cnt=0.
- BLINK: if cnt ≥ period then cnt <= 0 and `led` <= ~`led`; otherwise cnt <= cnt+1. The LED toggles every period+1 ticks. With period=0 it toggles every tick.
- PWM: `led` <= (cnt < duty); cnt <= (cnt ≥ period) ? 0 : cnt+1.
  - The frame is period+1 ticks, and the LED is high for the first min(duty, period+1) ticks of each frame.
  - duty=0 means always low; duty>period means always high.

Simultaneous events:
- A write and a tick on the same channel in the same cycle: the write wins and that channel does not advance. Other channels tick normally.
- A write and a deasserted `enable`: the write applies; counters stay frozen afterwards.

Counters never exceed period. When the counter is at its maximum, cnt+1 is never evaluated past period, so there is no overflow.

## Timing
- Write-to-output latency is 1 clk: `led` reflects the new mode at the edge that samples `cfg_we`.
- First BLINK toggle occurs on tick number period+1 after the write. With PRESCALE=1 that is period+1 cycles after the write edge.
- `cfg_err` asserts 1 cycle after the bad write and lasts 1 cycle.
- Reset assertion clears outputs immediately, without waiting for a clock edge. Deassertion is synchronised upstream; the first tick comes PRESCALE cycles after the first enabled edge.
- Reset mid-operation discards all configuration; channels return to OFF.

## Structure
- Package `led_pkg`: mode localparams LED_OFF, LED_ON, LED_BLINK, LED_PWM and the 2-bit `led_mode_t` typedef.
- Sub-module `led_channel`: holds one channel's mode, period, duty, cnt and led state. It takes inputs `tick`, `wr`, mode, period and duty.
- `led_ctrl`: prescaler, address decode, `cfg_err` logic, and a generate loop of CHANNELS `led_channel` instances.

## Test plan
- PRESCALE=1, write ch0 BLINK with period=10, then hold `enable`=1 → `led[0]` rises 11 cycles after the write and toggles every 11 cycles thereafter; other LEDs stay 0.
- PWM on ch1 with period=9, duty=3 → repeating 3 high / 7 low. Rewrite with duty=0 → constant 0. Rewrite with duty=12 → constant 1.
- Blink running on ch0 (period=10) with `enable` dropped for 5 cycles mid-period → the next toggle is delayed by exactly 5 cycles and the LED holds its value meanwhile.
- Write with `cfg_ch`=CHANNELS → `cfg_err` high for 1 cycle and no `led` change. Then write ch2 ON in the same cycle as a tick → `led[2]`=1 on the next edge and the other channels advance normally.
- PRESCALE=4, BLINK with period=2 → toggles every 12 cycles.
- Pull `reset_n` low between clock edges while channels are blinking or in PWM → `led`=0 immediately. After release all channels remain OFF until rewritten.
